// File: rtl/rx_word_buf.sv
// Receive-side first-word-fall-through word buffer between the serial receiver and a ready/valid consumer.
// Optional dropped-word statistics counter (o_drop_cnt) is built when RX_WORD_BUF_STAT_EN is defined.
module rx_word_buf #(
   parameter int DW    = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DW-1:0]            i_rx_data,
   input  logic                     i_rx_vld,
   output logic [DW-1:0]            o_st_data,
   output logic                     o_st_vld,
   input  logic                     i_st_rdy,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_full,
   output logic                     o_ovf,
   input  logic                     i_ovf_clr
`ifdef RX_WORD_BUF_STAT_EN
   ,
   output logic [15:0]              o_drop_cnt
`endif
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);
   localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
   localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;
   logic          ovf_q, ovf_d;
   logic          push, pop, drop;

   // Handshake: the receiver side has no backpressure (i_rx_vld is a strobe);
   // the consumer side transfers a word on any cycle where o_st_vld && i_st_rdy.
   assign o_st_vld  = (level_q != '0);
   assign o_full    = (level_q == LVL_FULL);
   assign o_level   = level_q;
   assign o_ovf     = ovf_q;
   assign o_st_data = o_st_vld ? mem_q[rd_ptr_q] : '0;

   assign pop  = o_st_vld & i_st_rdy;
   assign push = i_rx_vld & (~o_full | pop);
   assign drop = i_rx_vld & o_full & ~pop;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      ovf_d    = ovf_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase
      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)           ovf_d = 1'b1;
      else if (i_ovf_clr) ovf_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is left uncleared on reset; emptiness comes from level_q alone.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= i_rx_data;
   end

`ifdef RX_WORD_BUF_STAT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (i_ovf_clr)                      drop_cnt_d = {15'd0, drop};
      else if (drop && drop_cnt_q != '1)  drop_cnt_d = drop_cnt_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) drop_cnt_q <= '0;
      else        drop_cnt_q <= drop_cnt_d;
   end

   assign o_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rx_word_buf.sv
// Randomized scoreboard bench for rx_word_buf: driver updates a queue model, a negedge monitor checks popped words.
module tb_rx_word_buf;
  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] i_rx_data = '0;
  logic          i_rx_vld = 1'b0;
  logic [DW-1:0] o_st_data;
  logic          o_st_vld;
  logic          i_st_rdy = 1'b0;
  logic [LW-1:0] o_level;
  logic          o_full;
  logic          o_ovf;
  logic          i_ovf_clr = 1'b0;
`ifdef RX_WORD_BUF_STAT_EN
  logic [15:0]   o_drop_cnt;
`endif

  rx_word_buf #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_rx_data (i_rx_data),
    .i_rx_vld  (i_rx_vld),
    .o_st_data (o_st_data),
    .o_st_vld  (o_st_vld),
    .i_st_rdy  (i_st_rdy),
    .o_level   (o_level),
    .o_full    (o_full),
    .o_ovf     (o_ovf),
    .i_ovf_clr (i_ovf_clr)
`ifdef RX_WORD_BUF_STAT_EN
    ,
    .o_drop_cnt(o_drop_cnt)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: expected words in order, plus expected status
  logic [DW-1:0] exp_q[$];
  int            exp_level = 0;
  bit            exp_ovf = 1'b0;
  int            exp_drop = 0;
  int            n_pass = 0;
  int            n_total = 0;
  logic [DW-1:0] mon_exp;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    exp_level = 0;
    exp_ovf   = 1'b0;
    exp_drop  = 0;
  endfunction

  task automatic check_status();
    chk("level",  32'(o_level),  32'(exp_level));
    chk("full",   32'(o_full),   32'(exp_level == DEPTH));
    chk("st_vld", 32'(o_st_vld), 32'(exp_level != 0));
    chk("ovf",    32'(o_ovf),    32'(exp_ovf));
`ifdef RX_WORD_BUF_STAT_EN
    chk("drop_cnt", 32'(o_drop_cnt), 32'(exp_drop));
`endif
  endtask

  // driver: one clock cycle of stimulus; model follows the buffer rules directly
  task automatic cycle(input bit vld, input logic [DW-1:0] data, input bit rdy, input bit clr);
    bit will_pop;
    bit is_full;
    i_rx_vld  = vld;
    i_rx_data = data;
    i_st_rdy  = rdy;
    i_ovf_clr = clr;
    will_pop = (exp_level != 0) && rdy;
    is_full  = (exp_level == DEPTH);
    if (vld && (!is_full || will_pop)) begin
      exp_q.push_back(data);
      exp_level++;
    end
    if (will_pop) exp_level--;
    if (clr) begin
      exp_ovf  = 1'b0;
      exp_drop = 0;
    end
    if (vld && is_full && !will_pop) begin
      exp_ovf = 1'b1;
      if (exp_drop < 65535) exp_drop++;
    end
    @(posedge clk);
    #1;
    check_status();
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * DEPTH && exp_level != 0; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    chk("drained", 32'(exp_q.size()), 32'd0);
  endtask

  // monitor: a word leaves on every negedge-observed transfer
  always @(negedge clk) begin
    if (rst_n && o_st_vld && i_st_rdy) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 32'd1, 32'd0);
      else begin
        mon_exp = exp_q.pop_front();
        chk("st_data", 32'(o_st_data), 32'(mon_exp));
      end
    end
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level",  32'(o_level),   32'd0);
    chk("rst_st_vld", 32'(o_st_vld),  32'd0);
    chk("rst_full",   32'(o_full),    32'd0);
    chk("rst_ovf",    32'(o_ovf),     32'd0);
    chk("rst_data",   32'(o_st_data), 32'd0);
    rst_n = 1'b1;

    // single word, one-cycle latency, held while not ready
    cycle(1'b1, 16'h0001, 1'b0, 1'b0);
    chk("first_data", 32'(o_st_data), 32'h0001);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("hold_data", 32'(o_st_data), 32'h0001);
    drain();

    // fill, overflow, coincident drop+clear, full with simultaneous pop
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    cycle(1'b1, 16'h00AA, 1'b0, 1'b0);
    cycle(1'b1, 16'h00BB, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b1, 16'h00CC, 1'b1, 1'b0);
    drain();

    // continuous streaming through a ready consumer
    for (int i = 0; i < 1000; i++) cycle(1'b1, DW'(i), 1'b1, 1'b0);
    drain();

    // random traffic
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 1) == 1,
            $urandom_range(0, 19) == 0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    drain();

    // reset in the middle of a stream
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_st_vld", 32'(o_st_vld),  32'd0);
    chk("mid_rst_level",  32'(o_level),   32'd0);
    chk("mid_rst_data",   32'(o_st_data), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(1'b1, 16'h1234, 1'b0, 1'b0);
    chk("post_rst_data", 32'(o_st_data), 32'h1234);
    drain();

`ifdef RX_WORD_BUF_STAT_EN
    // drop counter saturation
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    chk("drop_sat", 32'(o_drop_cnt), 32'h0000FFFF);
    cycle(1'b0, '0, 1'b0, 1'b1);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rx_word_buf.md
RX_WORD_BUF -- requirements
Module: rx_word_buf

Interface
REQ-001 SHALL have parameter DW, default 16, word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16, buffer depth in words; power of 2, 4..256.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_rx_data  input  DW  word from the serial receiver (rcvr) stage.
REQ-006 SHALL have port i_rx_vld  input  1  one-cycle strobe, i_rx_data valid; no backpressure to the receiver.
REQ-007 SHALL have port o_st_data  output  DW  head-of-buffer word.
REQ-008 SHALL have port o_st_vld  output  1  o_st_data valid.
REQ-009 SHALL have port i_st_rdy  input  1  downstream consumer ready.
REQ-010 SHALL have port o_level  output  log2(DEPTH)+1  stored word count.
REQ-011 SHALL have port o_full  output  1  o_level == DEPTH.
REQ-012 SHALL have port o_ovf  output  1  sticky flag, word dropped.
REQ-013 SHALL have port i_ovf_clr  input  1  one-cycle clear of o_ovf.
REQ-014 SHALL have port o_drop_cnt  output  16  dropped-word count; present only with RX_WORD_BUF_STAT_EN.

Function
REQ-015 SHALL implement a first-word-fall-through circular buffer: write pointer, read pointer, level counter, each wrapping modulo DEPTH (pointers) without explicit compare-to-max.
REQ-016 SHALL define push = i_rx_vld and (not o_full, or pop in the same cycle).
REQ-017 SHALL define pop = o_st_vld and i_st_rdy.
REQ-018 SHALL on push store i_rx_data at write pointer and advance it by 1.
REQ-019 SHALL on pop advance read pointer by 1.
REQ-020 SHALL update o_level: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-021 SHALL drive o_st_vld = (o_level != 0), o_full and o_st_data from registered state; no combinational path from i_rx_vld or i_st_rdy to any output.
REQ-022 SHALL give latency 1: word pushed at edge N into empty buffer appears with o_st_vld=1 in the cycle after edge N.
REQ-023 SHALL hold o_st_data stable while o_st_vld=1 and i_st_rdy=0.
REQ-024 SHALL preserve strict word order; no word duplicated or reordered.
REQ-025 SHALL, when i_rx_vld=1, o_full=1 and no pop, drop the word, leave buffer unchanged and set o_ovf at the next edge.
REQ-026 SHALL clear o_ovf on i_ovf_clr; if drop and i_ovf_clr coincide, o_ovf SHALL be 1 (set wins).
REQ-027 SHALL ignore i_st_rdy when empty; pop on empty never occurs, o_level never underflows.

Reset
REQ-028 SHALL on rst_n=0 asynchronously clear pointers, o_level, o_ovf, o_drop_cnt; o_st_vld=0, o_full=0, o_st_data=0.
REQ-029 SHALL discard all stored words on reset asserted mid-operation; storage array need not be cleared.
REQ-030 SHALL accept a push on the first rising edge after rst_n deasserts.

Configuration
REQ-031 SHALL, with RX_WORD_BUF_STAT_EN defined, increment o_drop_cnt by 1 per dropped word, saturating at 16'hFFFF; i_ovf_clr SHALL also zero it (coincident drop then gives 1).
REQ-032 SHALL, without RX_WORD_BUF_STAT_EN, omit port o_drop_cnt and its counter; all other behaviour identical.

Verification
REQ-033 SHALL cover: reset, push 16'h0001 with i_st_rdy=0 -> next cycle o_st_vld=1, o_st_data=16'h0001, o_level=1.
REQ-034 SHALL cover: DEPTH=16, push 0..15, i_st_rdy=0 -> o_full=1, o_level=16; 17th push 16'h00AA -> o_ovf=1, o_drop_cnt=1, level 16; drain reads 0..15 in order.
REQ-035 SHALL cover: full buffer, i_rx_vld=1 and i_st_rdy=1 same cycle -> no drop, o_level stays 16, o_ovf stays 0.
REQ-036 SHALL cover: continuous push every cycle, i_st_rdy=1, 1000 words counting 0..999 -> output identical sequence, o_level <= 1, pointers wrap cleanly.
REQ-037 SHALL cover: level 5, rst_n pulled low mid-stream -> o_st_vld=0, o_level=0 immediately; post-reset push 16'h1234 is first word out.
REQ-038 SHALL cover: drop and i_ovf_clr same cycle -> o_ovf=1, o_drop_cnt=1 (STAT_EN); 70000 drops -> o_drop_cnt=16'hFFFF.
